// File: rtl/aac_pkg.sv
// Shared AAC definitions: default widths, result latency and the feeder state encoding,
// so the accumulator and its feeder agree on the frame timing.
package aac_pkg;

  localparam int AAC_DW      = 24;
  localparam int AAC_RES_LAT = 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/aac_feeder_buf.sv
// Sample buffer for the AAC feeder: one write port that appends at the fill count,
// and one registered read port that returns zero when not reading.
module aac_feeder_buf #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       we,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] count_reg;
  logic [DW-1:0] rd_data_reg;
  logic [AW-1:0] wr_addr;
  logic          do_write;

  assign wr_addr  = count_reg[AW-1:0];
  assign full     = (count_reg == CW'(DEPTH));
  assign do_write = we && !full;
  assign count    = count_reg;
  assign rd_data  = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first bypass covers a one-sample burst read on the same edge it is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (clr) begin
        count_reg <= '0;
      end else if (do_write) begin
        count_reg <= count_reg + CW'(1);
      end
      if (!rd_en) begin
        rd_data_reg <= '0;
      end else if (do_write && (wr_addr == rd_addr)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/aac_feeder.sv
// AAC initiator: buffers one burst, replays it as a single aac-high run, returns the result.
// Optional `ovf` output flagging DEPTH truncation is enabled by defining AAC_FEEDER_OVF_EN.
module aac_feeder
  import aac_pkg::*;
#(
  parameter int DW      = AAC_DW,
  parameter int DEPTH   = 16,
  parameter int RES_LAT = AAC_RES_LAT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_last,
  output logic                   aac,
  output logic [DW-1:0]          A_o,
  input  logic [DW-1:0]          acc_i,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic [$clog2(DEPTH):0] res_cnt,
  output logic                   busy
`ifdef AAC_FEEDER_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  feeder_state_e state_reg;
  logic          in_ready_reg;
  logic          aac_reg;
  logic          res_valid_reg;
  logic [DW-1:0] res_data_reg;
  logic [CW-1:0] res_cnt_reg;
  logic [CW-1:0] rd_cnt_reg;
  logic [LW-1:0] wait_cnt_reg;

  logic [CW-1:0] buf_cnt;
  logic          buf_full;
  logic          accept;
  logic          end_burst;
  logic          wait_done;
  logic          rd_en;
  logic          buf_clr;
  logic [AW-1:0] rd_addr;

  // The first read is issued on the accepting edge so aac rises one cycle after the last sample.
  always_comb begin
    accept    = (state_reg == FILL) && in_valid && in_ready_reg && !buf_full;
    end_burst = accept && (in_last || (buf_cnt == CW'(DEPTH - 1)));
    wait_done = (wait_cnt_reg == LW'(RES_LAT - 1));
    rd_en     = end_burst || ((state_reg == STREAM) && (rd_cnt_reg != buf_cnt));
    rd_addr   = (state_reg == STREAM) ? rd_cnt_reg[AW-1:0] : '0;
    buf_clr   = (state_reg == HOLD) && res_ready;
  end

  aac_feeder_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (buf_clr),
    .we      (accept),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (A_o),
    .full    (buf_full),
    .count   (buf_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      in_ready_reg  <= 1'b0;
      aac_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_cnt_reg   <= '0;
      rd_cnt_reg    <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      aac_reg <= rd_en;
      case (state_reg)
        FILL: begin
          if (end_burst) begin
            state_reg    <= STREAM;
            in_ready_reg <= 1'b0;
            rd_cnt_reg   <= CW'(1);
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_cnt_reg != buf_cnt) begin
            rd_cnt_reg <= rd_cnt_reg + CW'(1);
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= '0;
          end
        end
        WAIT: begin
          if (wait_done) begin
            res_data_reg  <= acc_i;
            res_cnt_reg   <= buf_cnt;
            res_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + LW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            rd_cnt_reg    <= '0;
            state_reg     <= FILL;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

`ifdef AAC_FEEDER_OVF_EN
  logic trunc_reg;
  logic ovf_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trunc_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (end_burst) begin
        trunc_reg <= !in_last;
      end
      if ((state_reg == WAIT) && wait_done) begin
        ovf_reg <= trunc_reg;
      end else if (buf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign ovf = ovf_reg;
`endif

  assign in_ready  = in_ready_reg;
  assign aac       = aac_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_cnt   = res_cnt_reg;
  assign busy      = !((state_reg == FILL) && (buf_cnt == '0));

endmodule

// File: tb/tb_aac_feeder.sv
// Self-checking bench for aac_feeder: directed table, hand sequences and randomized bursts
// scored against a burst/frame reference model; includes a behavioural AAC accumulator.
module tb_aac_feeder;
  import aac_pkg::*;

  localparam int DW      = AAC_DW;
  localparam int DEPTH   = 16;
  localparam int RES_LAT = AAC_RES_LAT;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data, A_o, acc_i, res_data;
  logic          aac, res_valid, res_ready, busy, ovf_w;
  logic [CW-1:0] res_cnt;
  logic          rdy_fixed, rdy_rand, rdy_mode;

  always #5 clk = ~clk;
  assign res_ready = rdy_mode ? rdy_rand : rdy_fixed;

  aac_feeder #(.DW(DW), .DEPTH(DEPTH), .RES_LAT(RES_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .aac       (aac),
    .A_o       (A_o),
    .acc_i     (acc_i),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cnt   (res_cnt),
    .busy      (busy)
`ifdef AAC_FEEDER_OVF_EN
    ,
    .ovf       (ovf_w)
`endif
  );
`ifndef AAC_FEEDER_OVF_EN
  assign ovf_w = 1'b0;
`endif

  // Behavioural AAC: a run of aac=1 is one frame, sum visible RES_LAT cycles after the last one.
  logic signed [DW-1:0] acc_pipe [RES_LAT];
  logic                 aac_prev;
  always @(posedge clk) begin
    if (aac) acc_pipe[0] <= aac_prev ? acc_pipe[0] + $signed(A_o) : $signed(A_o);
    for (int i = 1; i < RES_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
    aac_prev <= aac;
  end
  assign acc_i = acc_pipe[RES_LAT-1];

  typedef struct { longint data; int cnt; bit ovf; } res_t;
  typedef struct { int n; int d [4]; int exp_sum; } vec_t;

  res_t   got_q[$], exp_q[$];
  longint frame_sum_q[$], aval_q[$];
  int     frame_len_q[$], lat_q[$];
  int     pass_cnt = 0, tot_cnt = 0;
  vec_t   vecs [5];

  function automatic longint wrap(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return longint'(t);
  endfunction

  // Monitor: frames on aac, result latency, and handshakes, sampled between edges.
  int     cyc = 0, last_aac_cyc = 0, cur_len = 0;
  longint cur_sum = 0;
  logic   rv_prev = 1'b0;
  res_t   mon_r;
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      cur_len = 0; cur_sum = 0; rv_prev = 1'b0;
    end else begin
      cyc++;
      if (aac) begin
        cur_len++;
        cur_sum += longint'($signed(A_o));
        aval_q.push_back(longint'($signed(A_o)));
        last_aac_cyc = cyc;
      end else if (cur_len > 0) begin
        frame_len_q.push_back(cur_len);
        frame_sum_q.push_back(wrap(cur_sum));
        cur_len = 0; cur_sum = 0;
      end
      if (res_valid && !rv_prev) lat_q.push_back(cyc - last_aac_cyc);
      rv_prev = res_valid;
      if (res_valid && res_ready) begin
        mon_r.data = longint'($signed(res_data));
        mon_r.cnt  = int'(res_cnt);
        mon_r.ovf  = ovf_w;
        got_q.push_back(mon_r);
      end
    end
  end

  initial begin
    rdy_rand = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic timeout_fail(input string name);
    tot_cnt++;
    $display("FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); frame_sum_q.delete(); frame_len_q.delete();
    lat_q.delete(); aval_q.delete();
  endtask

  task automatic push_sample(input longint d, input bit l);
    int guard;
    in_valid = 1'b1; in_last = l; in_data = d[DW-1:0];
    guard = 0;
    while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) timeout_fail("in_ready_wait");
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_burst(input longint vals[$]);
    foreach (vals[i]) push_sample(vals[i], i == vals.size() - 1);
  endtask

  task automatic add_exp(input longint data, input int cnt, input bit ovf);
    res_t r;
    r.data = data; r.cnt = cnt; r.ovf = ovf;
    exp_q.push_back(r);
  endtask

  // Reference: an upstream burst splits into frames at in_last or at DEPTH samples.
  task automatic model_burst(input longint vals[$]);
    longint sum = 0;
    int     cnt = 0;
    bit     is_last;
    foreach (vals[i]) begin
      sum += vals[i]; cnt++;
      is_last = (i == vals.size() - 1);
      if (is_last || cnt == DEPTH) begin
        add_exp(wrap(sum), cnt, !is_last);
        sum = 0; cnt = 0;
      end
    end
  endtask

  task automatic wait_results(input int n);
    int guard = 0;
    while (got_q.size() < n && guard < 4000) begin @(negedge clk); guard++; end
    if (got_q.size() < n) timeout_fail("result_wait");
  endtask

  task automatic check_results(input string tag);
    repeat (5) @(negedge clk);
    check($sformatf("%s_nres", tag), got_q.size(), exp_q.size());
    check($sformatf("%s_nframes", tag), frame_len_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < got_q.size()) begin
        $display("%s result %0d: data=%0d cnt=%0d ovf=%0d (exp %0d/%0d/%0d)", tag, k,
                 got_q[k].data, got_q[k].cnt, got_q[k].ovf, exp_q[k].data, exp_q[k].cnt, exp_q[k].ovf);
        check($sformatf("%s_data%0d", tag, k), got_q[k].data, exp_q[k].data);
        check($sformatf("%s_cnt%0d", tag, k), got_q[k].cnt, exp_q[k].cnt);
`ifdef AAC_FEEDER_OVF_EN
        check($sformatf("%s_ovf%0d", tag, k), got_q[k].ovf, exp_q[k].ovf);
`endif
      end
      if (k < frame_len_q.size()) begin
        check($sformatf("%s_aaclen%0d", tag, k), frame_len_q[k], exp_q[k].cnt);
        check($sformatf("%s_aacsum%0d", tag, k), frame_sum_q[k], exp_q[k].data);
      end
      if (k < lat_q.size()) check($sformatf("%s_lat%0d", tag, k), lat_q[k], RES_LAT + 1);
    end
  endtask

  task automatic set_vec(input int i, input int n, input int d0, input int d1,
                         input int d2, input int d3, input int s);
    vecs[i].n = n; vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
    vecs[i].exp_sum = s;
  endtask

  initial begin
    longint vals[$];
    int     bad_data, bad_rdy, bad_aac, guard, len;
    logic signed [DW-1:0] r;

    set_vec(0, 3, 3, 7, -2, 0, 8);
    set_vec(1, 1, -8388608, 0, 0, 0, -8388608);
    set_vec(2, 2, 8388607, 1, 0, 0, -8388608);
    set_vec(3, 2, -5, -6, 0, 0, -11);
    set_vec(4, 4, 1, -1, 100, 23, 123);

    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rdy_fixed = 1'b1; rdy_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_aac", aac, 0);
    check("rst_A_o", A_o, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    check("busy_idle", busy, 0);

    // Directed table
    foreach (vecs[v]) begin
      clear_logs();
      vals.delete();
      for (int i = 0; i < vecs[v].n; i++) vals.push_back(longint'(vecs[v].d[i]));
      add_exp(longint'(vecs[v].exp_sum), vecs[v].n, 1'b0);
      send_burst(vals);
      wait_results(1);
      check($sformatf("vec%0d_nA", v), aval_q.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < aval_q.size(); i++)
        check($sformatf("vec%0d_A%0d", v, i), aval_q[i], longint'(vecs[v].d[i]));
      check_results($sformatf("vec%0d", v));
    end

    // 20 ones, last only on the 20th: truncated at DEPTH, remainder becomes a new frame
    clear_logs();
    add_exp(16, 16, 1'b1);
    add_exp(4, 4, 1'b0);
    for (int i = 0; i < 20; i++) push_sample(1, i == 19);
    wait_results(2);
    check_results("trunc");

    // Back-to-back bursts 5,5 then 1
    clear_logs();
    add_exp(10, 2, 1'b0);
    add_exp(1, 1, 1'b0);
    push_sample(5, 1'b0); push_sample(5, 1'b1); push_sample(1, 1'b1);
    wait_results(2);
    check_results("b2b");

    // Result held off for 10 cycles
    clear_logs();
    rdy_fixed = 1'b0;
    push_sample(1, 1'b0); push_sample(2, 1'b0); push_sample(3, 1'b1);
    guard = 0;
    while (!res_valid && guard < 200) begin @(negedge clk); guard++; end
    if (!res_valid) timeout_fail("hold_res_valid");
    bad_data = 0; bad_rdy = 0; bad_aac = 0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || $signed(res_data) != 6 || res_cnt != 3) bad_data++;
      if (in_ready) bad_rdy++;
      if (aac) bad_aac++;
    end
    check("hold_result_stable_bad_cycles", bad_data, 0);
    check("hold_in_ready_bad_cycles", bad_rdy, 0);
    check("hold_aac_bad_cycles", bad_aac, 0);
    check("hold_busy", busy, 1);
    rdy_fixed = 1'b1;
    @(negedge clk);
    check("hold_res_valid_after_hs", res_valid, 0);
    check("hold_in_ready_after_hs", in_ready, 1);
    check("hold_nres", got_q.size(), 1);
    if (got_q.size() > 0) check("hold_data", got_q[0].data, 6);

    // Reset on the 2nd STREAM cycle of a 4-sample burst
    clear_logs();
    push_sample(1, 1'b0); push_sample(1, 1'b0); push_sample(1, 1'b0); push_sample(1, 1'b1);
    check("rst_mid_stream1_aac", aac, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_aac", aac, 0);
    check("rst_mid_A_o", A_o, 0);
    check("rst_mid_res_valid", res_valid, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    @(negedge clk);
    add_exp(2, 1, 1'b0);
    push_sample(2, 1'b1);
    wait_results(1);
    check_results("post_rst");

    // Randomized bursts with random res_ready
    clear_logs();
    rdy_mode = 1'b1;
    for (int b = 0; b < 25; b++) begin
      len = (b == 0) ? 16 : (b == 1) ? 17 : (b == 2) ? 32 : $urandom_range(1, 20);
      vals.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 4))
          0:       r = {1'b1, {(DW-1){1'b0}}};
          1:       r = {1'b0, {(DW-1){1'b1}}};
          2:       r = DW'($urandom_range(0, 20)) - DW'(10);
          default: r = DW'($urandom);
        endcase
        vals.push_back(longint'(r));
      end
      model_burst(vals);
      send_burst(vals);
    end
    wait_results(exp_q.size());
    check_results("rnd");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
